// File: rtl/puf_pkg.sv
// Shared definitions for the PUF word sequencer: FSM encoding, challenge LFSR taps, seed guard.
// Pure declarations, no logic of its own; no latency or backpressure.
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Feedback taps at bits 7,5,4,3 give a maximal-length 8-bit sequence
    localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/chall_lfsr.sv
// 8-bit challenge register: load wins over advance, new value visible the cycle after the edge.
// No backpressure; the caller decides when to load or step.
module chall_lfsr
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/puf_word_sequencer.sv
// Drives one puf_bit through an LFSR challenge walk and packs its responses LSB-first into a word.
// Latency N_BITS*(1+RUN cycles) from start; word held in DONE until resp_ready, start ignored while busy.
module puf_word_sequencer #(
    parameter int N_BITS  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        seed,
    output logic [7:0]        chall,
    output logic              puf_en,
    output logic              puf_clr,
    input  logic              puf_resp,
    input  logic              puf_finish,
    output logic              busy,
    output logic [N_BITS-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              timeout_err
);
    import puf_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [CNT_W-1:0]  run_cnt;
    logic [IDX_W-1:0]  idx;

    logic start_acc;
    logic in_run;
    logic bit_done;
    logic last_bit;
    logic [7:0] seed_eff;

    logic puf_en_d;
    logic puf_clr_d;
    logic busy_d;
    logic resp_valid_d;

    assign start_acc = (state == ST_IDLE) && start;
    assign in_run    = (state == ST_RUN);
    // A finish landing on the last allowed cycle still counts as a real response
    assign bit_done  = in_run && (puf_finish || (run_cnt == CNT_LAST));
    assign last_bit  = (idx == IDX_LAST);
    assign seed_eff  = (seed == 8'h00) ? ZERO_SEED_SUB : seed;

    chall_lfsr u_chall_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val (seed_eff),
        .advance  (bit_done && !last_bit),
        .value    (chall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            puf_en     <= 1'b0;
            puf_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= next_state;
            puf_en     <= puf_en_d;
            puf_clr    <= puf_clr_d;
            busy       <= busy_d;
            resp_valid <= resp_valid_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CLEAR;
            ST_CLEAR: next_state = ST_RUN;
            ST_RUN:   if (bit_done) next_state = last_bit ? ST_DONE : ST_CLEAR;
            ST_DONE:  if (resp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they can be registered alongside the state
    always_comb begin
        puf_en_d     = (next_state == ST_RUN);
        puf_clr_d    = (next_state == ST_CLEAR);
        busy_d       = (next_state != ST_IDLE);
        resp_valid_d = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_word   <= '0;
            idx         <= '0;
            run_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            resp_word   <= '0;
            idx         <= '0;
            run_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (in_run) begin
            if (bit_done) begin
                resp_word[idx] <= puf_finish ? puf_resp : 1'b0;
                if (!puf_finish) begin
                    timeout_err <= 1'b1;
                end
                run_cnt <= '0;
                if (!last_bit) begin
                    idx <= idx + IDX_ONE;
                end
            end else begin
                run_cnt <= run_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_puf_word_sequencer.sv
// Directed bench for puf_word_sequencer with a behavioural puf_bit model (N_BITS=8, TIMEOUT=4).
module tb_puf_word_sequencer;

    localparam int N_BITS  = 8;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        seed = 8'h00;
    logic [7:0]        chall;
    logic              puf_en;
    logic              puf_clr;
    logic              puf_resp = 1'b0;
    logic              puf_finish = 1'b0;
    logic              busy;
    logic [N_BITS-1:0] resp_word;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // PUF model configuration: RUN cycle (1-based) on which finish rises, 0 = never
    int         fin_delay [N_BITS];
    logic       resp_pat  [N_BITS];
    logic [7:0] chall_log [N_BITS];
    int         en_cycles [N_BITS];
    int         model_bit = -1;
    int         run_cnt   = 0;
    int         clr_count = 0;

    always #5 clk = ~clk;

    puf_word_sequencer #(
        .N_BITS  (N_BITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .chall       (chall),
        .puf_en      (puf_en),
        .puf_clr     (puf_clr),
        .puf_resp    (puf_resp),
        .puf_finish  (puf_finish),
        .busy        (busy),
        .resp_word   (resp_word),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .timeout_err (timeout_err)
    );

    always @(negedge clk) begin
        if (puf_clr) begin
            model_bit  = model_bit + 1;
            run_cnt    = 0;
            puf_finish = 1'b0;
            clr_count++;
            if (model_bit >= 0 && model_bit < N_BITS) begin
                chall_log[model_bit] = chall;
                en_cycles[model_bit] = 0;
            end
        end else if (puf_en) begin
            run_cnt++;
            if (model_bit >= 0 && model_bit < N_BITS) begin
                en_cycles[model_bit]++;
                if (fin_delay[model_bit] != 0 && run_cnt == fin_delay[model_bit]) begin
                    puf_finish = 1'b1;
                    puf_resp   = resp_pat[model_bit];
                end
            end
        end else begin
            puf_finish = 1'b0;
        end
    end

    task automatic set_model(input logic [7:0] pat, input int d);
        for (int i = 0; i < N_BITS; i++) begin
            resp_pat[i]  = pat[i];
            fin_delay[i] = d;
            en_cycles[i] = 0;
            chall_log[i] = 8'h00;
        end
    endtask

    task automatic run_word(input logic [7:0] s, input bit ack,
                            output logic [N_BITS-1:0] w, output logic te,
                            output int lat, output logic [1:0] first_bc);
        model_bit = -1;
        clr_count = 0;
        lat       = 0;
        first_bc  = 2'b00;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start    = 1'b0;
                first_bc = {busy, puf_clr};
            end
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_wait: resp_valid never rose for seed %h", s);
        end
        w  = resp_word;
        te = timeout_err;
        if (ack) begin
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({chall, resp_word} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: chall/resp_word = %h, expected 0000", {chall, resp_word});
        end
        n_tests++;
        if ({puf_en, puf_clr, busy, resp_valid, timeout_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: en/clr/busy/valid/terr = %b, expected 00000",
                     {puf_en, puf_clr, busy, resp_valid, timeout_err});
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy = %b without start, expected 0", busy);
        end
    endtask

    task automatic test_sequence();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        logic [7:0]        exp_ch [5];
        exp_ch = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        set_model(8'h00, 3);
        run_word(8'h01, 1'b1, w, te, lat, bc);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (chall_log[i] !== exp_ch[i]) begin
                n_fail++;
                $display("FAIL seq_chall%0d: got %h, expected %h", i, chall_log[i], exp_ch[i]);
            end
        end
        n_tests++;
        if (clr_count !== N_BITS) begin
            n_fail++;
            $display("FAIL seq_clr_count: got %0d pulses, expected %0d", clr_count, N_BITS);
        end
        n_tests++;
        if (bc !== 2'b11) begin
            n_fail++;
            $display("FAIL seq_start_flags: busy/clr after start = %b, expected 11", bc);
        end
        n_tests++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL seq_latency: resp_valid after %0d cycles, expected 33", lat);
        end
        n_tests++;
        if (w !== 8'h00 || te !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_word: word %h terr %b, expected 00 0", w, te);
        end
    endtask

    task automatic test_latency();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        set_model(8'h3C, 1);
        run_word(8'h77, 1'b1, w, te, lat, bc);
        n_tests++;
        if (lat !== 2 * N_BITS + 1) begin
            n_fail++;
            $display("FAIL fast_latency: resp_valid after %0d cycles, expected %0d", lat, 2 * N_BITS + 1);
        end
        n_tests++;
        if (w !== 8'h3C) begin
            n_fail++;
            $display("FAIL fast_word: got %h, expected 3c", w);
        end
    endtask

    task automatic test_word_assembly();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        set_model(8'h4D, 1);
        for (int i = 0; i < N_BITS; i++) fin_delay[i] = (i % 3) + 1;
        run_word(8'h9E, 1'b1, w, te, lat, bc);
        n_tests++;
        if (w !== 8'h4D) begin
            n_fail++;
            $display("FAIL word_assembly: got %h, expected 4d", w);
        end
        n_tests++;
        if (te !== 1'b0) begin
            n_fail++;
            $display("FAIL word_terr: got %b, expected 0", te);
        end
    endtask

    task automatic test_zero_seed();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        set_model(8'h00, 1);
        run_word(8'h00, 1'b1, w, te, lat, bc);
        n_tests++;
        if (chall_log[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL zero_seed_first: got %h, expected 01", chall_log[0]);
        end
        n_tests++;
        if (chall_log[1] !== 8'h02) begin
            n_fail++;
            $display("FAIL zero_seed_second: got %h, expected 02", chall_log[1]);
        end
    endtask

    task automatic test_timeout();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        set_model(8'hFF, 1);
        fin_delay[2] = 0;
        run_word(8'h21, 1'b1, w, te, lat, bc);
        n_tests++;
        if (w !== 8'hFB || te !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_word: word %h terr %b, expected fb 1", w, te);
        end
        n_tests++;
        if (en_cycles[2] !== TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_run_len: bit 2 ran %0d cycles, expected %0d", en_cycles[2], TIMEOUT);
        end
        n_tests++;
        if (en_cycles[3] !== 1) begin
            n_fail++;
            $display("FAIL timeout_next_bit: bit 3 ran %0d cycles, expected 1", en_cycles[3]);
        end
    endtask

    task automatic test_finish_at_timeout();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        set_model(8'hFF, 1);
        fin_delay[5] = TIMEOUT;
        run_word(8'h21, 1'b1, w, te, lat, bc);
        n_tests++;
        if (w !== 8'hFF || te !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_finish_word: word %h terr %b, expected ff 0", w, te);
        end
        n_tests++;
        if (en_cycles[5] !== TIMEOUT) begin
            n_fail++;
            $display("FAIL edge_finish_len: bit 5 ran %0d cycles, expected %0d", en_cycles[5], TIMEOUT);
        end
    endtask

    task automatic test_backpressure();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        bit                stable;
        set_model(8'hA5, 1);
        run_word(8'h33, 1'b0, w, te, lat, bc);
        n_tests++;
        if (w !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_word: got %h, expected a5", w);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_word !== 8'hA5 || busy !== 1'b1 || puf_clr !== 1'b0)
                stable = 1'b0;
        end
        n_tests++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: word/valid disturbed while stalled, now valid %b word %h busy %b",
                     resp_valid, resp_word, busy);
        end
        start      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: valid %b busy %b, expected 0 0", resp_valid, busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || puf_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_restart: busy %b clr %b, expected 0 0", busy, puf_clr);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N_BITS-1:0] w;
        logic              te;
        int                lat;
        logic [1:0]        bc;
        bit                found;
        set_model(8'hFF, 3);
        fin_delay[3] = 0;
        model_bit = -1;
        @(negedge clk);
        seed  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (model_bit == 3 && puf_en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_reach: bit 3 RUN never seen, model_bit %0d", model_bit);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({chall, resp_word} !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_data: chall/resp_word = %h, expected 0000", {chall, resp_word});
        end
        n_tests++;
        if ({puf_en, puf_clr, busy, resp_valid, timeout_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: en/clr/busy/valid/terr = %b, expected 00000",
                     {puf_en, puf_clr, busy, resp_valid, timeout_err});
        end
        @(negedge clk);
        rst = 1'b1;
        set_model(8'h4D, 2);
        run_word(8'h5A, 1'b1, w, te, lat, bc);
        n_tests++;
        if (w !== 8'h4D || te !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_reword: word %h terr %b, expected 4d 0", w, te);
        end
        n_tests++;
        if (chall_log[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_mid_chall: first chall %h, expected 5a", chall_log[0]);
        end
    endtask

    initial begin
        set_model(8'h00, 1);
        test_reset();
        test_sequence();
        test_latency();
        test_word_assembly();
        test_zero_seed();
        test_timeout();
        test_finish_at_timeout();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_word_sequencer.md
# puf_word_sequencer

Control stage that drives one `puf_bit` instance and assembles its single-bit responses into an N-bit PUF response word. On `start` it walks a deterministic LFSR sequence of 8-bit challenges from a user seed. For each challenge it clears the PUF bit, enables it, and waits for `finish`. It then shifts `resp` into the word and presents the completed word on a valid/ready output.

## Interface
Parameters:
- `N_BITS`, default 8: response bits per word (1..32).
- `TIMEOUT`, default 1023: max RUN cycles per bit before abort (≥1).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new word; sampled only in IDLE.
- `seed`  in  8  first challenge; latched on accepted `start`.
- `chall`  out  8  challenge to `puf_bit`; registered.
- `puf_en`  out  1  enable to `puf_bit`.
- `puf_clr`  out  1  one-cycle clear pulse to `puf_bit` reset input.
- `puf_resp`  in  1  `puf_bit` response.
- `puf_finish`  in  1  `puf_bit` done (level).
- `busy`  out  1  high in any state except IDLE.
- `resp_word`  out  N_BITS  assembled response, LSB = first challenge.
- `resp_valid`  out  1  word available.
- `resp_ready`  in  1  consumer accepts word.
- `timeout_err`  out  1  at least one bit in the current word timed out; valid with `resp_valid`.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - `start`=1 latches the challenge: `seed`, or 0x01 if `seed`=0x00 (LFSR lock-up guard).
  - Also clears `resp_word`, the bit index, and `timeout_err`, then enters CLEAR.
- CLEAR, exactly 1 cycle: `puf_clr`=1, `puf_en`=0, `chall` stable. Next state is RUN.
- RUN: `puf_en`=1, `puf_clr`=0, and the timeout counter increments each cycle.
  - Finish: `puf_finish`=1 writes `puf_resp` into `resp_word[idx]`.
  - Timeout: counter reaching `TIMEOUT` without finish writes 0 into `resp_word[idx]` and sets `timeout_err`.
  - On either event, if `idx`=N_BITS-1, go to DONE.
  - Otherwise increment `idx`, advance `chall`, clear the counter, and go to CLEAR.
  - Finish and timeout in the same cycle count as finish; `timeout_err` is not set.
- Challenge advance: `chall_next` = {chall[6:0], chall[7]^chall[5]^chall[4]^chall[3]}, a maximal-length 8-bit LFSR.
- DONE: `resp_valid`=1 and `resp_word`/`timeout_err` are held stable. `resp_ready`=1 returns to IDLE with `resp_valid` cleared.
- `start` outside IDLE is ignored and not queued. `start` and `resp_ready` high together in DONE: the handshake completes, and `start` is not seen until IDLE.
- Reset, asynchronous at any time:
  - state becomes IDLE;
  - `chall`, `resp_word`, `idx`, counter = 0;
  - `puf_en`, `puf_clr`, `busy`, `resp_valid`, `timeout_err` = 0.
  - Reset mid-word discards partial results.

## Timing
- All outputs are registered.
- Accepted `start` at edge k: `busy`=1 and `puf_clr`=1 from k+1.
- Per bit: 1 CLEAR cycle, then RUN until finish.
  - Finish sampled at edge m: `puf_en` drops after m (in CLEAR or DONE).
  - Next `puf_clr` is at m+1; the new `chall` is visible the same cycle.
- Word latency is N_BITS × (1 + RUN cycles). For a finish on the first RUN cycle of each bit, `resp_valid` rises 2·N_BITS cycles after the `start` edge.
- `puf_finish` is ignored in IDLE, CLEAR and DONE.
- Timeout bit: RUN lasts exactly `TIMEOUT` cycles.
- Counter width is clog2(TIMEOUT+1). Index width is clog2(N_BITS), minimum 1.

## Structure
- Shared package/header `puf_pkg`:
  - state encodings;
  - LFSR tap constant (bits 7,5,4,3);
  - zero-seed substitute 0x01.
- Sub-module `chall_lfsr` (load, advance, 8-bit state). The FSM, counters and shift/assembly logic stay in `puf_word_sequencer`.

## Test plan
- Sequence check: seed 0x01, N_BITS=5, model finishes 3 cycles after each `puf_clr` → `chall` sequence 0x01,0x02,0x04,0x08,0x11; one `puf_clr` pulse per bit.
- Word assembly: N_BITS=8, model `resp` pattern 1,0,1,1,0,0,1,0 (first→last) → `resp_word`=0x4D, `timeout_err`=0.
- Zero seed: seed 0x00 → first `chall`=0x01.
- Timeout: TIMEOUT=4, model never finishes bit 2 (others resp=1), N_BITS=4 → bit-2 RUN lasts 4 cycles, `resp_word`=0xB, `timeout_err`=1.
- Backpressure: hold `resp_ready`=0 for 10 cycles in DONE with `start` pulsed → word stable, no restart. `resp_ready`=1 → IDLE the next cycle.
- Reset mid-RUN: assert `rst`=0 during bit 3 → all outputs 0 immediately. After release, a new `start` produces a correct full word.
